vga_timing_gen: RTL and testbench

Raster-scan initiator for the VGA display path. Generates the pixel-rate enable, the horizontal and vertical counters, and the xx/yy/aactive coordinate stream that sprite renderers consume. Also drives the hsync/vsync pins and emits line and frame strobes. Default timing is 640x480@60 with a 100 MHz Pclk divided by 4.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/pixel_tick_div.sv | 32 +++
 rtl/vga_timing_gen.sv | 110 +++++++++++
 tb/tb_vga_timing_gen.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers for the raster-scan initiator.
// Default timing is 640x480@60 with a 100 MHz Pclk divided by 4.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_CLK_DIV  = 4;

  localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned COORD_LIMIT = 1 << COORD_W;

  // Half-open window test lo <= c < hi, done at 32 bits so hi may equal COORD_LIMIT.
  function automatic logic in_window(input logic [COORD_W-1:0] c,
                                     input int unsigned lo,
                                     input int unsigned hi);
    int unsigned cu;
    cu = 32'(c);
    return (cu >= lo) && (cu < hi);
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Pixel clock-enable divider: pix_tick is high during the Pclk cycle whose
// closing edge advances the raster by one pixel (every CLK_DIV cycles).
module pixel_tick_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic Pclk,
  input  logic rst_n,
  output logic pix_tick
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("pixel_tick_div: CLK_DIV must be >= 1");
  end

  logic [DivW-1:0] div_q, div_d;

  assign pix_tick = (div_q == DivMax);

  always_comb begin
    div_d = div_q + 1'b1;
    if (pix_tick) div_d = '0;
  end

  always_ff @(posedge Pclk) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel enable, xx/yy/aactive stream, sync pins and strobes.
// Optional frame_cnt output is enabled by defining VGA_TIMING_FRAME_COUNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic               Pclk,
  input  logic               rst_n,
  output logic               pix_tick,
  output logic [COORD_W-1:0] xx,
  output logic [COORD_W-1:0] yy,
  output logic               aactive,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
`ifdef VGA_TIMING_FRAME_COUNT_EN
  output logic [7:0]         frame_cnt,
`endif
  output logic               frame_start
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [COORD_W-1:0] HMax = COORD_W'(HTotal - 1);
  localparam logic [COORD_W-1:0] VMax = COORD_W'(VTotal - 1);
  localparam int unsigned HSyncLo = H_ACTIVE + H_FP;
  localparam int unsigned HSyncHi = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VSyncLo = V_ACTIVE + V_FP;
  localparam int unsigned VSyncHi = V_ACTIVE + V_FP + V_SYNC;

  if (HTotal > COORD_LIMIT || VTotal > COORD_LIMIT) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
  end

  logic adv;

  pixel_tick_div #(
    .CLK_DIV(CLK_DIV)
  ) u_pixel_tick_div (
    .Pclk    (Pclk),
    .rst_n   (rst_n),
    .pix_tick(adv)
  );

  logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
  logic               line_wrap, frame_wrap;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (adv) begin
      if (h_q == HMax) begin
        h_d = '0;
        v_d = (v_q == VMax) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    line_wrap  = adv && (h_d == '0);
    frame_wrap = line_wrap && (v_d == '0);
  end

  // Outputs are decoded from the next-state counters so they all move on the tick edge.
  always_ff @(posedge Pclk) begin
    if (!rst_n) begin
      h_q         <= HMax;
      v_q         <= VMax;
      pix_tick    <= 1'b0;
      xx          <= '0;
      yy          <= '0;
      aactive     <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      pix_tick    <= adv;
      line_start  <= line_wrap;
      frame_start <= frame_wrap;
      if (adv) begin
        xx      <= h_d;
        yy      <= v_d;
        aactive <= in_window(h_d, 0, H_ACTIVE) && in_window(v_d, 0, V_ACTIVE);
        hsync   <= in_window(h_d, HSyncLo, HSyncHi) ? HSYNC_POL : ~HSYNC_POL;
        vsync   <= in_window(v_d, VSyncLo, VSyncHi) ? VSYNC_POL : ~VSYNC_POL;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_COUNT_EN
  always_ff @(posedge Pclk) begin
    if (!rst_n)          frame_cnt <= '0;
    else if (frame_wrap) frame_cnt <= frame_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing at CLK_DIV=4 plus a
// small-raster instance at CLK_DIV=1 for full-frame, wrap and frame counter checks.
module tb_vga_timing_gen;

  logic Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  logic       rst_n, rst_s_n;
  logic       pix_tick, aactive, hsync, vsync, line_start, frame_start;
  logic [9:0] xx, yy;
  logic       pix_tick_s, aactive_s, hsync_s, vsync_s, line_start_s, frame_start_s;
  logic [9:0] xx_s, yy_s;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [7:0] frame_cnt, frame_cnt_s;
`endif

  vga_timing_gen u_dut (
    .Pclk       (Pclk),
    .rst_n      (rst_n),
    .pix_tick   (pix_tick),
    .xx         (xx),
    .yy         (yy),
    .aactive    (aactive),
    .hsync      (hsync),
    .vsync      (vsync),
    .line_start (line_start),
`ifdef VGA_TIMING_FRAME_COUNT_EN
    .frame_cnt  (frame_cnt),
`endif
    .frame_start(frame_start)
  );

  // 15 x 9 raster: hsync active-high on xx 10..12, vsync active-low on yy 6..7.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
  ) u_dut_s (
    .Pclk       (Pclk),
    .rst_n      (rst_s_n),
    .pix_tick   (pix_tick_s),
    .xx         (xx_s),
    .yy         (yy_s),
    .aactive    (aactive_s),
    .hsync      (hsync_s),
    .vsync      (vsync_s),
    .line_start (line_start_s),
`ifdef VGA_TIMING_FRAME_COUNT_EN
    .frame_cnt  (frame_cnt_s),
`endif
    .frame_start(frame_start_s)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Pclk);
    #1;
  endtask

  task automatic check_reset_main(input string tag);
    check({tag, " pix_tick"}, 32'(pix_tick), 0);
    check({tag, " xx"}, 32'(xx), 0);
    check({tag, " yy"}, 32'(yy), 0);
    check({tag, " aactive"}, 32'(aactive), 0);
    check({tag, " line_start"}, 32'(line_start), 0);
    check({tag, " frame_start"}, 32'(frame_start), 0);
    check({tag, " hsync"}, 32'(hsync), 1);
    check({tag, " vsync"}, 32'(vsync), 1);
  endtask

  task automatic release_main(input string tag);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check({tag, " pre pix_tick"}, 32'(pix_tick), 0);
      check({tag, " pre xx"}, 32'(xx), 0);
      check({tag, " pre aactive"}, 32'(aactive), 0);
      check({tag, " pre frame_start"}, 32'(frame_start), 0);
      check({tag, " pre hsync"}, 32'(hsync), 1);
    end
    step();
    check({tag, " tick pix_tick"}, 32'(pix_tick), 1);
    check({tag, " tick xx"}, 32'(xx), 0);
    check({tag, " tick yy"}, 32'(yy), 0);
    check({tag, " tick aactive"}, 32'(aactive), 1);
    check({tag, " tick frame_start"}, 32'(frame_start), 1);
    check({tag, " tick line_start"}, 32'(line_start), 1);
    check({tag, " tick hsync"}, 32'(hsync), 1);
    check({tag, " tick vsync"}, 32'(vsync), 1);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    check({tag, " tick frame_cnt"}, 32'(frame_cnt), 1);
`endif
    step();
    check({tag, " post pix_tick"}, 32'(pix_tick), 0);
    check({tag, " post frame_start"}, 32'(frame_start), 0);
    check({tag, " post line_start"}, 32'(line_start), 0);
    check({tag, " post xx hold"}, 32'(xx), 0);
  endtask

  // Advances the small instance through n frame_start pulses, bounded by a cycle budget.
  task automatic wait_frames_s(input int n, input string tag);
    int seen = 0;
    for (int i = 0; i < n * 135 + 200 && seen < n; i++) begin
      step();
      if (frame_start_s) seen++;
    end
    check({tag, " frame_start count"}, 32'(seen), 32'(n));
  endtask

  initial begin
    rst_n   = 1'b0;
    rst_s_n = 1'b0;

    // Reset and first tick after release at CLK_DIV=4.
    step();
    step();
    check_reset_main("reset");
    release_main("release");

    // One full line of the default raster.
    begin
      int ticks = 0, act = 1, hlow = 0, first_low = -1, seq_bad = 0;
      bit done = 1'b0;
      logic [9:0] prev;
      prev = xx;
      for (int i = 0; i < 4000 && !done; i++) begin
        step();
        if (pix_tick) begin
          ticks++;
          if (line_start) begin
            done = 1'b1;
          end else begin
            if (32'(xx) != 32'(prev) + 1) seq_bad++;
            prev = xx;
            if (aactive) act++;
            if (!hsync) begin
              if (hlow == 0) first_low = int'(xx);
              hlow++;
            end
          end
        end else if (xx !== prev) begin
          seq_bad++;
        end
      end
      check("line bound", 32'(done), 1);
      check("line ticks", 32'(ticks), 800);
      check("line active", 32'(act), 640);
      check("line hsync low", 32'(hlow), 96);
      check("line hsync start", 32'(first_low), 656);
      check("line sequence", 32'(seq_bad), 0);
      check("line wrap xx", 32'(xx), 0);
      check("line wrap yy", 32'(yy), 1);
      check("line wrap frame_start", 32'(frame_start), 0);
    end

    // Mid-line reset: position is discarded and the release sequence repeats.
    for (int i = 0; i < 2000 && xx != 10'd300; i++) step();
    check("midrst reached xx", 32'(xx), 300);
    rst_n = 1'b0;
    step();
    check_reset_main("midrst");
    release_main("rerelease");

    // Small raster at CLK_DIV=1: reset, first tick, full frame with wraps.
    step();
    check("s reset pix_tick", 32'(pix_tick_s), 0);
    check("s reset hsync", 32'(hsync_s), 0);
    check("s reset vsync", 32'(vsync_s), 1);
    rst_s_n = 1'b1;
    step();
    check("s first pix_tick", 32'(pix_tick_s), 1);
    check("s first frame_start", 32'(frame_start_s), 1);
    check("s first xx", 32'(xx_s), 0);
    check("s first yy", 32'(yy_s), 0);
    check("s first aactive", 32'(aactive_s), 1);
    check("s first hsync", 32'(hsync_s), 0);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    check("s frame_cnt 1", 32'(frame_cnt_s), 1);
`endif
    begin
      int cycles = 0, vlow = 0, vbad = 0, hhi = 0, act = 1, bad_act = 0, no_tick = 0;
      bit done = 1'b0;
      logic [9:0] px, py;
      px = xx_s;
      py = yy_s;
      for (int i = 0; i < 1000 && !done; i++) begin
        step();
        cycles++;
        if (!pix_tick_s) no_tick++;
        if (px == 10'd14 && py == 10'd8) begin
          check("s frame wrap xx", 32'(xx_s), 0);
          check("s frame wrap yy", 32'(yy_s), 0);
          check("s frame wrap frame_start", 32'(frame_start_s), 1);
        end
        if (px == 10'd14 && py == 10'd2) begin
          check("s line wrap xx", 32'(xx_s), 0);
          check("s line wrap yy", 32'(yy_s), 3);
          check("s line wrap line_start", 32'(line_start_s), 1);
          check("s line wrap frame_start", 32'(frame_start_s), 0);
        end
        if (frame_start_s) begin
          done = 1'b1;
        end else begin
          if (aactive_s) act++;
          if (aactive_s && yy_s >= 10'd4) bad_act++;
          if (!vsync_s) begin
            vlow++;
            if (yy_s < 10'd6 || yy_s > 10'd7) vbad++;
          end
          if (hsync_s) hhi++;
        end
        px = xx_s;
        py = yy_s;
      end
      check("s frame bound", 32'(done), 1);
      check("s frame cycles", 32'(cycles), 135);
      check("s every cycle ticks", 32'(no_tick), 0);
      check("s vsync low", 32'(vlow), 30);
      check("s vsync window", 32'(vbad), 0);
      check("s hsync high", 32'(hhi), 27);
      check("s active", 32'(act), 32);
      check("s active below vactive", 32'(bad_act), 0);
    end

`ifdef VGA_TIMING_FRAME_COUNT_EN
    check("s frame_cnt 2", 32'(frame_cnt_s), 2);
    wait_frames_s(1, "s third frame");
    check("s frame_cnt 3", 32'(frame_cnt_s), 3);
    wait_frames_s(252, "s to 255");
    check("s frame_cnt 255", 32'(frame_cnt_s), 255);
    wait_frames_s(1, "s 256th frame");
    check("s frame_cnt wrap", 32'(frame_cnt_s), 0);
`else
    wait_frames_s(2, "s extra frames");
    check("s xx after frames", 32'(xx_s), 0);
    check("s yy after frames", 32'(yy_s), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
